// File: rtl/lbp_hist.sv
// 256-bin histogram of one frame's LBP codes, streamed out over valid/ready on finish, then cleared.
// Optional address/protocol checker is compiled in with `LBP_HIST_ADDR_CHK_EN`.
module lbp_hist #(
  parameter int BINS = 256,
  parameter int CW   = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          lbp_valid,
  input  logic [13:0]   lbp_addr,
  input  logic [7:0]    lbp_data,
  input  logic          finish,
  output logic          hist_valid,
  input  logic          hist_ready,
  output logic [7:0]    hist_bin,
  output logic [CW-1:0] hist_count,
  output logic          hist_done,
  output logic          err
);

  typedef enum logic [1:0] {
    S_ACCUM = 2'd0,
    S_DUMP  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_rd_idx;
  logic          w_rd_inc;
  logic          w_acc;
  logic [CW-1:0] r_bin [BINS];

  assign w_acc = (r_state == S_ACCUM) && lbp_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_inc    = 1'b0;
    case (r_state)
      S_ACCUM: begin
        if (finish) begin
          w_state_nxt = S_DUMP;
        end
      end
      S_DUMP: begin
        if (hist_ready) begin
          w_rd_inc = 1'b1;
          if (r_rd_idx == 8'hFF) begin
            w_state_nxt = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        w_state_nxt = S_ACCUM;
      end
      default: begin
        w_state_nxt = S_ACCUM;
      end
    endcase
  end

  // Readout index wraps to 0 naturally on the bin-255 transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_idx <= 8'd0;
    end else if (w_rd_inc) begin
      r_rd_idx <= r_rd_idx + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BINS; i++) begin
        r_bin[i] <= '0;
      end
    end else if (r_state == S_CLEAR) begin
      for (int i = 0; i < BINS; i++) begin
        r_bin[i] <= '0;
      end
    end else if (w_acc) begin
      r_bin[lbp_data] <= r_bin[lbp_data] + CW'(1);
    end
  end

  assign hist_valid = (r_state == S_DUMP);
  assign hist_bin   = hist_valid ? r_rd_idx : 8'd0;
  assign hist_count = hist_valid ? r_bin[r_rd_idx] : '0;
  assign hist_done  = (r_state == S_CLEAR);

`ifdef LBP_HIST_ADDR_CHK_EN
  logic [6:0]  r_yexp;
  logic [6:0]  r_xexp;
  logic        r_err;
  logic [13:0] w_addr_exp;
  logic        w_err_set;

  assign w_addr_exp = {r_yexp, r_xexp};

  always_comb begin
    w_err_set = 1'b0;
    if (w_acc && (lbp_addr != w_addr_exp)) begin
      w_err_set = 1'b1;
    end
    if ((r_state == S_ACCUM) && finish &&
        (!lbp_valid || (lbp_addr != {7'd126, 7'd126}))) begin
      w_err_set = 1'b1;
    end
    if (lbp_valid && (r_state != S_ACCUM)) begin
      w_err_set = 1'b1;
    end
  end

  // Raster tracker walks the 126x126 interior starting at {1,1}.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_yexp <= 7'd1;
      r_xexp <= 7'd1;
      r_err  <= 1'b0;
    end else begin
      r_err <= r_err | w_err_set;
      if (r_state == S_CLEAR) begin
        r_yexp <= 7'd1;
        r_xexp <= 7'd1;
      end else if (w_acc) begin
        if (r_xexp == 7'd126) begin
          r_xexp <= 7'd1;
          r_yexp <= r_yexp + 7'd1;
        end else begin
          r_xexp <= r_xexp + 7'd1;
        end
      end
    end
  end

  assign err = r_err;
`else
  logic w_unused_addr;
  assign w_unused_addr = ^lbp_addr;
  assign err = 1'b0;
`endif

endmodule

// File: doc/lbp_hist.md
# lbp_hist

Downstream consumer of the LBP feature stage. Accumulates a 256-bin histogram of the LBP codes written for one 128×128 frame, whose 126×126 interior gives 15876 codes. When the stage signals `finish`, the block streams all bins out through a valid/ready port, then clears itself for the next frame. It sits between the LBP stage's write port (`lbp_addr`/`lbp_valid`/`lbp_data`/`finish`) and the feature-vector sink.

## Interface
Parameters:
- `BINS`, 256: number of histogram bins. Fixed at 256; one bin per 8-bit code.
- `CW`, 14: bin counter width. 15876 < 2^14, so counters never overflow within one frame.

Ports:
- `clk` input 1: single clock. All logic is rising-edge.
- `reset` input 1: asynchronous, active-high reset.
- `lbp_valid` input 1: one LBP code is presented this cycle.
- `lbp_addr` input 14: pixel address `{Y[6:0],X[6:0]}`. Used only under `LBP_HIST_ADDR_CHK_EN`.
- `lbp_data` input 8: LBP code, used as the bin index.
- `finish` input 1: last code of the frame. It is coincident with the final `lbp_valid`.
- `hist_valid` output 1: readout beat is valid.
- `hist_ready` input 1: sink accepts the beat.
- `hist_bin` output 8: bin index of the current beat.
- `hist_count` output 14: count held in bin `hist_bin`.
- `hist_done` output 1: one-cycle pulse after bin 255 transfers.
- `err` output 1: sticky protocol-error flag. Tied 0 unless the check is compiled in.

## Operation
- Storage is 256 × 14-bit counter registers plus an 8-bit readout index `rd_idx`.
- The state machine has three states: ACCUM, DUMP, CLEAR.
- ACCUM (the reset state):
  - Each cycle with `lbp_valid=1`, `bin[lbp_data]` is incremented at that same edge. One code per cycle, no stalls, no read-modify-write hazard.
  - If `finish=1` with `lbp_valid=1`, the final code is counted and the next state is DUMP.
  - `finish` without `lbp_valid` also moves to DUMP and flags `err` under the check.
- DUMP:
  - `hist_valid=1`, `hist_bin=rd_idx`, `hist_count=bin[rd_idx]` (combinational mux).
  - On `hist_valid & hist_ready`, `rd_idx` increments.
  - The transfer at `rd_idx=255` moves to CLEAR and wraps `rd_idx` to 0.
  - While `hist_ready=0`, all outputs hold stable.
  - `lbp_valid` in DUMP is dropped (not counted) and flags `err` under the check.
- CLEAR (one cycle):
  - `hist_done=1`, `hist_valid=0`.
  - All bins are zeroed at the edge, and the next state is ACCUM.
  - `lbp_valid` in CLEAR is dropped and flags `err`.
- Increment arithmetic is modulo 2^14. Overflow is unreachable for a legal frame and is not detected.

## Timing
- Reset values:
  - state ACCUM, all bins 0, `rd_idx` 0
  - `hist_valid` 0, `hist_bin` 0, `hist_count` 0, `hist_done` 0, `err` 0
- Accumulate latency: a code presented at edge N is visible in its bin after edge N.
- DUMP entry: the edge that samples `finish` moves to DUMP. `hist_valid` rises in the next cycle with bin 0.
- Readout timing: minimum 256 cycles with `hist_ready` held high. CLEAR follows, then ACCUM.
- Total turnaround from `finish` to ready-for-next-frame is 258 cycles minimum.
- Reset asserted mid-DUMP or mid-ACCUM returns immediately to the reset state. Bins clear and any partial readout is abandoned.
- `hist_done` is registered state-decode only. It never coincides with `hist_valid`.

## Configuration
- `LBP_HIST_ADDR_CHK_EN` defined:
  - An expected-address tracker `{Yexp,Xexp}` starts at `{1,1}`.
  - On each accepted code, Xexp goes 1..126; after 126, Xexp returns to 1 and Yexp increments.
  - `lbp_addr != {Yexp,Xexp}` sets `err`.
  - `finish` with an address other than `{126,126}` sets `err`.
  - `lbp_valid` outside ACCUM sets `err`.
  - `err` is sticky until reset. The tracker resets to `{1,1}` in CLEAR.
- `LBP_HIST_ADDR_CHK_EN` undefined: `lbp_addr` is ignored, `err` is constant 0, and no tracker logic exists.

## Test plan
- **Full frame:** a raster of 15876 codes, all `8'h00`, with `finish` on the last. Readout gives bin 0 = 15876 and bins 1–255 = 0. `hist_done` pulses once, one cycle after the bin-255 transfer.
- **Mixed codes:** 10 × `8'hFF`, 3 × `8'h1C`, 1 × `8'h00` (with `finish`). Readout gives bin 255=10, bin 28=3, bin 0=1, all others 0.
- **Back-pressure:** `hist_ready` toggles 1/0 every cycle during DUMP. The readout takes 512 cycles, with `hist_bin`/`hist_count` stable on every stalled cycle and no bin skipped or repeated.
- **Frame-to-frame clear:**
  - Frame 1 of 5 × `8'h3C`, then frame 2 of 2 × `8'h3C`.
  - The second readout shows bin 60=2, not 7.
- **Reset mid-DUMP:** assert `reset` at `rd_idx`=100. `hist_valid` goes 0 immediately. A new frame of one code `8'h01` with `finish` reads back bin 1=1.
- **Address check (macro defined):**
  - Second code sent with `lbp_addr={1,3}` sets `err=1`, which stays high through DUMP until reset.
  - With the macro undefined, the same stimulus leaves `err=0`.
